// File: rtl/fwd_scoreboard.sv
// Hazard scoreboard for a 5-stage pipeline: tracks E/M/W destination tags,
// raises stall on Tuse/Tnew conflicts and on a busy mult/div unit, and
// drives the D, E and M forwarding mux selects combinationally.
module fwd_scoreboard (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_tuse_rs,
   input  logic [1:0] D_tuse_rt,
   input  logic [4:0] D_A3,
   input  logic [1:0] D_tnew,
   input  logic       D_md_start,
   input  logic       D_md_is_div,
   input  logic       D_md_use,
   output logic       stall,
   output logic [1:0] FW_D_rs,
   output logic [1:0] FW_D_rt,
   output logic [1:0] FW_E_rs,
   output logic [1:0] FW_E_rt,
   output logic [1:0] FW_M_rt,
   output logic       md_busy
);

   // E keeps the whole tag plus the mult/div launch info. Downstream only
   // the fields that still feed a decision are kept: M needs rt (store
   // data), A3 and tnew; W's tnew is always 0 and its sources are dead, so
   // only its A3 survives.
   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] a3;
      logic [1:0] tnew;
      logic       md_start;
      logic       md_div;
   } e_tag_t;

   typedef struct packed {
      logic [4:0] rt;
      logic [4:0] a3;
      logic [1:0] tnew;
   } m_tag_t;

   localparam logic [3:0] MULT_CYC = 4'd5;
   localparam logic [3:0] DIV_CYC  = 4'd10;

   e_tag_t     e_q, e_d;
   m_tag_t     m_q, m_d;
   logic [4:0] w_a3_q, w_a3_d;
   logic [3:0] mdc_q, mdc_d;
   logic       stall_data, stall_md;

   // $0 is hard-wired, so a write to it never creates a dependency.
   function automatic logic hit(input logic [4:0] a3, input logic [4:0] s);
      return (s != 5'd0) && (a3 == s);
   endfunction

   // A source stalls when a producer still in E or M delivers later than
   // the consumer needs it; tuse == 3 marks an unused source.
   function automatic logic src_stall(input logic [4:0] s, input logic [1:0] tuse,
                                      input e_tag_t e, input m_tag_t m);
      if (tuse == 2'd3) return 1'b0;
      return (hit(e.a3, s) && (e.tnew > tuse)) || (hit(m.a3, s) && (m.tnew > tuse));
   endfunction

   // D-stage select: youngest stage whose result is already available.
   function automatic logic [1:0] fwd_d(input logic [4:0] s, input e_tag_t e,
                                        input m_tag_t m, input logic [4:0] w_a3);
      if (hit(e.a3, s) && (e.tnew == 2'd0)) return 2'd3;
      if (hit(m.a3, s) && (m.tnew == 2'd0)) return 2'd2;
      if (hit(w_a3, s))                     return 2'd1;
      return 2'd0;
   endfunction

   // E-stage select: M result (if ready) beats W result.
   function automatic logic [1:0] fwd_e(input logic [4:0] s, input m_tag_t m,
                                        input logic [4:0] w_a3);
      if (hit(m.a3, s) && (m.tnew == 2'd0)) return 2'd2;
      if (hit(w_a3, s))                     return 2'd1;
      return 2'd0;
   endfunction

   // Stall and forwarding selects, combinational from tags and D inputs.
   always_comb begin
      md_busy    = (mdc_q != 4'd0) || e_q.md_start;
      stall_md   = (D_md_start || D_md_use) && md_busy;
      stall_data = src_stall(D_rs, D_tuse_rs, e_q, m_q) ||
                   src_stall(D_rt, D_tuse_rt, e_q, m_q);
      stall      = stall_data || stall_md;
      FW_D_rs    = fwd_d(D_rs, e_q, m_q, w_a3_q);
      FW_D_rt    = fwd_d(D_rt, e_q, m_q, w_a3_q);
      FW_E_rs    = fwd_e(e_q.rs, m_q, w_a3_q);
      FW_E_rt    = fwd_e(e_q.rt, m_q, w_a3_q);
      FW_M_rt    = {1'b0, hit(w_a3_q, m_q.rt)};
   end

   // Next tags: D enters E unless stalled (bubble), E/M/W always advance;
   // the MDU counter launches from E and otherwise drains to zero.
   always_comb begin
      e_d = '0;
      if (!stall) begin
         e_d.rs       = D_rs;
         e_d.rt       = D_rt;
         e_d.a3       = D_A3;
         e_d.tnew     = D_tnew;
         e_d.md_start = D_md_start;
         e_d.md_div   = D_md_is_div;
      end
      m_d.rt   = e_q.rt;
      m_d.a3   = e_q.a3;
      m_d.tnew = (e_q.tnew != 2'd0) ? e_q.tnew - 2'd1 : 2'd0;
      w_a3_d   = m_q.a3;
      mdc_d    = mdc_q;
      if (e_q.md_start)        mdc_d = e_q.md_div ? DIV_CYC : MULT_CYC;
      else if (mdc_q != 4'd0)  mdc_d = mdc_q - 4'd1;
   end

   // Pipeline tag and counter registers; reset aborts everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_q    <= '0;
         m_q    <= '0;
         w_a3_q <= '0;
         mdc_q  <= '0;
      end else begin
         e_q    <= e_d;
         m_q    <= m_d;
         w_a3_q <= w_a3_d;
         mdc_q  <= mdc_d;
      end
   end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have inputs D_rs, D_rt (5 bits each): source register numbers of the D-stage instruction.
REQ-004 SHALL have inputs D_tuse_rs, D_tuse_rt (2 bits each, 0..2): cycles until each source is needed; 3 means not used.
REQ-005 SHALL have inputs D_A3 (5 bits) and D_tnew (2 bits, 0..2): D-stage destination register and its Tnew relative to E entry.
REQ-006 SHALL have inputs D_md_start (1), D_md_is_div (1) and D_md_use (1): D-stage mult/div start, div flag, and HI/LO access.
REQ-007 SHALL have output stall (1): freeze F/D and insert an E bubble.
REQ-008 SHALL have outputs FW_D_rs, FW_D_rt (2 bits): 0 = GRF, 1 = W result, 2 = M result, 3 = E result.
REQ-009 SHALL have outputs FW_E_rs, FW_E_rt (2 bits): 0 = E-pipeline register, 1 = W result, 2 = M result.
REQ-010 SHALL have output FW_M_rt (2 bits): 0 = M-pipeline rt value, 1 = W result; this drives the DM write-data forwarding mux.
REQ-011 SHALL have output md_busy (1): the mult/div unit is occupied.

Function
REQ-012 SHALL keep registered tags {rs, rt, A3, tnew} for the E, M and W stages.
REQ-013 On each clk without stall, SHALL load the E tag from the D inputs.
REQ-014 On stall, SHALL load the E tag with a bubble: all fields zero.
REQ-015 SHALL always load M from E with tnew = max(E.tnew-1, 0), and W from M with tnew = 0.
REQ-016 SHALL treat register 0 as never matching for either stall or forwarding.
REQ-017 SHALL raise the data-stall condition for each used source s when either holds:
- E.A3 == s and E.tnew > tuse_s
- M.A3 == s and M.tnew > tuse_s
REQ-018 FW_D_x SHALL select the youngest matching stage:
- E when E.A3 matches and E.tnew == 0
- else M when M.A3 matches and M.tnew == 0
- else W when W.A3 matches
- else 0
REQ-019 FW_E_x SHALL use E.rs/E.rt against M (M.tnew == 0 required), then W; M has priority over W.
REQ-020 FW_M_rt SHALL be 1 when M.rt != 0 and W.A3 == M.rt, else 0.
REQ-021 All FW outputs SHALL be combinational from the current tags and D inputs: zero added latency.
REQ-022 SHALL hold a 4-bit MDU down-counter.
REQ-023 When the E tag holds a started md op, SHALL load the counter with 5 (mult) or 10 (div) on the next edge.
REQ-024 Otherwise the counter SHALL decrement when nonzero and hold at 0.
REQ-025 md_busy SHALL equal (counter != 0) OR (E holds an md start).
REQ-026 SHALL raise stall when (D_md_start OR D_md_use) AND md_busy.
REQ-027 stall SHALL be the OR of the data-stall and MDU-stall conditions.
REQ-028 A D instruction held by stall SHALL re-evaluate every cycle and proceed in the first cycle stall is 0.

Reset
REQ-029 Reset SHALL clear all E/M/W tags and the MDU counter to 0.
REQ-030 With reset asserted, all outputs SHALL read 0 on the cycle after the reset edge.
REQ-031 Reset asserted mid-stall or mid-MDU-count SHALL abort the operation; stall and md_busy SHALL be 0 the following cycle.

Verification
REQ-032 Load-use: lw to $8 (D_tnew=2) followed by add using $8 with tuse=1 -> stall=1 for exactly 1 cycle, then FW_D_rs=0 and FW_E_rs=1.
REQ-033 ALU chain: add $9 (tnew=1) followed by sub reading $9 with tuse=1 -> no stall; FW_E_rs=2 at E.
REQ-034 DM store: add $10 followed immediately by sw with rt=$10 -> FW_M_rt=1 when sw is in M and add is in W.
REQ-035 $0 writer: instruction with A3=0, tnew=2 followed by a reader of $0 -> stall=0 and all FW=0.
REQ-036 MDU: div, then mfhi in D -> stall=1 for 11 cycles (E cycle plus 10 counts); mult -> 6 cycles.
REQ-037 Reset during a div count at counter=4 -> md_busy=0 and stall=0 on the next cycle.
